// File: rtl/vga_hvsync_generator_if.sv
// Raster timing bundle: sync pulses, visible-area flag and pixel coordinates.
// The generator drives it (master); rendering logic consumes it (slave).
interface vga_hvsync_generator_if;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;

  modport master (
    output hsync, vsync, display_on, hpos, vpos
  );

  modport slave (
    input hsync, vsync, display_on, hpos, vpos
  );
endinterface

// File: rtl/vga_hvsync_generator.sv
// Free-running VGA raster timing generator (640x480@60 by default).
// Pixel/line counters with sync pulses registered from next-state counts so they line up with hpos/vpos.
module vga_hvsync_generator #(
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_BOTTOM        = 10,
  parameter int V_SYNC          = 2,
  parameter int V_TOP           = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_hvsync_generator_if.master vga
);

  localparam logic [9:0] H_DISP_W     = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP_W     = 10'(V_DISPLAY);
  localparam logic [9:0] H_MAX        = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX        = 10'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
  localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic       SYNC_ON      = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic       SYNC_OFF     = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_end;

  // Wrap on >= so the counters can never leave their legal range.
  always_comb begin
    line_end = (hpos_q >= H_MAX);
    hpos_d   = line_end ? 10'd0 : hpos_q + 10'd1;
    vpos_d   = vpos_q;
    if (line_end) begin
      vpos_d = (vpos_q >= V_MAX) ? 10'd0 : vpos_q + 10'd1;
    end
    hsync_d = ((hpos_d >= H_SYNC_START) && (hpos_d <= H_SYNC_END)) ? SYNC_ON : SYNC_OFF;
    vsync_d = ((vpos_d >= V_SYNC_START) && (vpos_d <= V_SYNC_END)) ? SYNC_ON : SYNC_OFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q  <= 10'd0;
      vpos_q  <= 10'd0;
      hsync_q <= SYNC_OFF;
      vsync_q <= SYNC_OFF;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga.hpos       = hpos_q;
  assign vga.vpos       = vpos_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.display_on = (hpos_q < H_DISP_W) && (vpos_q < V_DISP_W);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Bench for vga_hvsync_generator: a shrunken raster checked cycle by cycle against a reference model,
// plus a default-timing instance checked over its first line.
module tb_vga_hvsync_generator;

  localparam int HD = 16, HF = 4, HS = 6, HB = 4;
  localparam int VD = 12, VB = 3, VS = 2, VT = 4;
  localparam int HMAX  = HD + HF + HS + HB - 1;
  localparam int VMAX  = VD + VB + VS + VT - 1;
  localparam int HSS   = HD + HF;
  localparam int HSE   = HSS + HS - 1;
  localparam int VSS   = VD + VB;
  localparam int VSE   = VSS + VS - 1;
  localparam int FRAME = (HMAX + 1) * (VMAX + 1);

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
  } obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_hvsync_generator_if sif ();
  vga_hvsync_generator_if dif ();

  vga_hvsync_generator #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .vga(sif)
  );

  vga_hvsync_generator dut_def (
    .clk(clk), .reset(reset), .vga(dif)
  );

  int tests = 0, failed = 0;
  obs_t sb[$];
  int mh = 0, mv = 0;
  int cyc = 0, phase = 0;
  int zeros = 0, last_zero = 0, period = 0, dup = 0;
  bit prev_zero = 1'b0;
  int hslow = 0, vslow = 0, de_blank = 0, de_total = 0, maxh = 0, maxv = 0;
  int dlow = 0, dfirst = -1, dlast = -1;
  logic d_de639, d_de640;
  logic [9:0] dh800, dv800;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t model(input int h, input int v);
    obs_t o;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hs = !(h >= HSS && h <= HSE);
    o.vs = !(v >= VSS && v <= VSE);
    o.de = (h < HD) && (v < VD);
    return o;
  endfunction

  task automatic tick();
    obs_t e, g;
    @(posedge clk);
    if (mh >= HMAX) begin
      mh = 0;
      mv = (mv >= VMAX) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    sb.push_back(model(mh, mv));
    #1;
    cyc++;
    g = {sif.hpos, sif.vpos, sif.hsync, sif.vsync, sif.display_on};
    e = sb.pop_front();
    chk("raster", 32'(g), 32'(e));
    if (g.h == 10'd0 && g.v == 10'd0) begin
      zeros++;
      period    = cyc - last_zero;
      last_zero = cyc;
      if (prev_zero) dup++;
    end
    prev_zero = (g.h == 10'd0 && g.v == 10'd0);
    if (phase == 0) begin
      if (!g.hs) hslow++;
      if (!g.vs) vslow++;
      if (g.de) de_total++;
      if (g.de && int'(g.v) >= VD) de_blank++;
      if (int'(g.h) > maxh) maxh = int'(g.h);
      if (int'(g.v) > maxv) maxv = int'(g.v);
      if (cyc <= 800 && dif.vpos == 10'd0 && dif.hsync == 1'b0) begin
        dlow++;
        if (dfirst < 0) dfirst = int'(dif.hpos);
        dlast = int'(dif.hpos);
      end
      if (cyc == 639) d_de639 = dif.display_on;
      if (cyc == 640) d_de640 = dif.display_on;
      if (cyc == 800) begin
        dh800 = dif.hpos;
        dv800 = dif.vpos;
      end
    end
  endtask

  task automatic run_to(input int h, input int v, input string tag);
    int n = 0;
    while (!(sif.hpos == 10'(h) && sif.vpos == 10'(v)) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, {12'd0, sif.hpos, sif.vpos}, {12'd0, 10'(h), 10'(v)});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hpos"}, 32'(sif.hpos), 0);
    chk({tag, "_vpos"}, 32'(sif.vpos), 0);
    chk({tag, "_sync"}, {30'd0, sif.hsync, sif.vsync}, 32'b11);
    chk({tag, "_de"}, 32'(sif.display_on), 1);
    chk({tag, "_def"}, {10'd0, dif.hpos, dif.vpos, dif.hsync, dif.vsync}, {10'd0, 20'd0, 2'b11});
  endtask

  initial begin
    // Asynchronous reset between edges: no clock edge until t=5.
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_async");
    @(negedge clk);
    reset = 1'b0;
    mh = 0; mv = 0; cyc = 0; last_zero = 0; prev_zero = 1'b0;

    tick();
    chk("first_edge_h", 32'(sif.hpos), 1);
    chk("first_edge_v", 32'(sif.vpos), 0);

    run_to(HD - 1, 0, "de_last_col");  chk("de_last_col", 32'(sif.display_on), 1);
    run_to(HD, 0, "de_off_col");       chk("de_off_col", 32'(sif.display_on), 0);
    run_to(HSS - 1, 0, "hs_pre");      chk("hs_pre", 32'(sif.hsync), 1);
    run_to(HSS, 0, "hs_start");        chk("hs_start", 32'(sif.hsync), 0);
    run_to(HSE, 0, "hs_end");          chk("hs_end", 32'(sif.hsync), 0);
    run_to(HSE + 1, 0, "hs_post");     chk("hs_post", 32'(sif.hsync), 1);
    run_to(HMAX, 0, "line_end");
    tick();
    chk("line_wrap", {12'd0, sif.hpos, sif.vpos}, {12'd0, 10'd0, 10'd1});
    chk("line_period", 32'(cyc), 32'(HMAX + 1));
    run_to(0, VD - 1, "de_last_row");  chk("de_last_row", 32'(sif.display_on), 1);
    run_to(0, VD, "de_off_row");       chk("de_off_row", 32'(sif.display_on), 0);
    run_to(HMAX, VSS - 1, "vs_pre");   chk("vs_pre", 32'(sif.vsync), 1);
    run_to(0, VSS, "vs_start");        chk("vs_start", 32'(sif.vsync), 0);
    run_to(HMAX, VSE, "vs_end");       chk("vs_end", 32'(sif.vsync), 0);
    run_to(0, VSE + 1, "vs_post");     chk("vs_post", 32'(sif.vsync), 1);
    run_to(HMAX, VMAX, "frame_end");
    tick();
    chk("frame_wrap", {12'd0, sif.hpos, sif.vpos}, 32'd0);
    chk("frame1_len", 32'(cyc), 32'(FRAME));
    tick();
    run_to(0, 0, "frame2");
    chk("frame2_len", 32'(cyc), 32'(2 * FRAME));

    chk("zero_count", 32'(zeros), 2);
    chk("zero_period", 32'(period), 32'(FRAME));
    chk("zero_dup", 32'(dup), 0);
    chk("hsync_clocks", 32'(hslow), 32'(2 * HS * (VMAX + 1)));
    chk("vsync_clocks", 32'(vslow), 32'(2 * VS * (HMAX + 1)));
    chk("de_blank_lines", 32'(de_blank), 0);
    chk("de_total", 32'(de_total), 32'(2 * HD * VD));
    chk("max_h", 32'(maxh), 32'(HMAX));
    chk("max_v", 32'(maxv), 32'(VMAX));

    chk("def_hsync_len", 32'(dlow), 96);
    chk("def_hsync_first", 32'(dfirst), 656);
    chk("def_hsync_last", 32'(dlast), 751);
    chk("def_de_639", 32'(d_de639), 1);
    chk("def_de_640", 32'(d_de640), 0);
    chk("def_clk800", {12'd0, dh800, dv800}, {12'd0, 10'd0, 10'd1});

    // Mid-frame reset, asserted between edges.
    phase = 1;
    run_to(22, 10, "mid_frame");
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_mid");
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    mh = 0; mv = 0; cyc = 0; last_zero = 0; prev_zero = 1'b0;
    tick();
    chk("restart", {12'd0, sif.hpos, sif.vpos}, {12'd0, 10'd1, 10'd0});
    run_to(0, 0, "restart_frame");
    chk("restart_frame_len", 32'(cyc), 32'(FRAME));
    chk("restart_queue_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vga_hvsync_generator.md
Name: vga_hvsync_generator

Overview:
- Free-running VGA raster timing generator; defaults give 640x480 @ 60 Hz from a 25.175/25 MHz pixel clock.
- Produces horizontal/vertical sync, a display-active flag and the current pixel coordinates.
- Sits between the pixel clock and all pixel-rendering logic, such as sprite and ball position updates, text ROM lookup and colour mux.
- Rendering logic uses hpos/vpos as (x, y) and display_on for blanking.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_DISPLAY, 480, visible lines per frame
- V_BOTTOM, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_TOP, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 while asserted; 0 = drive 1

Ports:
- clk, input, 1, pixel clock; all state updates on its rising edge
- reset, input, 1, asynchronous active-high reset
- hsync, output, 1, horizontal sync, registered
- vsync, output, 1, vertical sync, registered
- display_on, output, 1, high when the current pixel is in the visible area
- hpos, output, 10, current horizontal pixel counter
- vpos, output, 10, current vertical line counter

Behaviour:
- Derived constants:
  - H_MAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1 (799)
  - V_MAX = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP-1 (524)
  - H_SYNC_START = H_DISPLAY+H_FRONT (656), H_SYNC_END = H_SYNC_START+H_SYNC-1 (751)
  - V_SYNC_START = V_DISPLAY+V_BOTTOM (490), V_SYNC_END = V_SYNC_START+V_SYNC-1 (491)
- Reset (asynchronous, while reset=1): hpos=0, vpos=0, hsync and vsync at inactive level (1 when SYNC_ACTIVE_LOW=1), display_on=1.
- hpos increments by 1 each clock. At H_MAX it wraps to 0 on the next clock (line end).
- vpos increments by 1 only on a line-end clock. If vpos=V_MAX on that clock, it wraps to 0 instead.
- hpos=H_MAX and vpos=V_MAX together: both wrap to 0 on the same edge (frame end).
- Counters never exceed their MAX; no other count values are reachable.
- hsync and vsync are registered from next-state counter values, so they align with the same-cycle hpos/vpos with zero lag:
  - hsync asserted exactly when H_SYNC_START <= hpos <= H_SYNC_END.
  - vsync asserted exactly when V_SYNC_START <= vpos <= V_SYNC_END, for every hpos of those lines.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY). It is combinational from the counter registers, so it has no lag relative to hpos/vpos.
- hpos/vpos are driven directly from the counter registers.
- Downstream logic uses hpos=0 && vpos=0 as the once-per-frame update strobe. The generator guarantees this state lasts exactly 1 clock per frame.
- Timing per frame:
  - Line period (H_MAX+1) = 800 clocks.
  - Frame period 800*525 = 420000 clocks.
  - 96 hsync clocks per line; 2 vsync lines = 1600 clocks per frame.
- Reset mid-frame: outputs return to reset values immediately, without waiting for a clock. After release, counting restarts at (0,0) on the first rising edge, and the first full frame is 420000 clocks.
- No enable input; the counters never stall.

Test Plan:
- Reset: assert reset asynchronously between clock edges -> hpos=0, vpos=0, hsync=1, vsync=1, display_on=1 without any clock edge. Release -> first edge gives hpos=1, vpos=0.
- Line timing from reset:
  - hsync=1 for hpos 0..655, hsync=0 for hpos 656..751 (96 clocks), hsync=1 for hpos 752..799.
  - At clock 800 after release: hpos=0, vpos=1.
- Display window:
  - display_on=1 at (639,0) and 0 at (640,0).
  - display_on=1 at (0,479) and 0 at (0,480).
  - display_on=0 for all of lines 480..524.
- Vertical sync: vsync=0 from (0,490) through (799,491), i.e. 1600 clocks; vsync=1 at (0,492) and at (799,489).
- Frame wrap:
  - At (799,524) the next edge gives (0,0).
  - (0,0) recurs every 420000 clocks and lasts exactly 1 clock.
  - Over 2 frames, hpos never exceeds 799 and vpos never exceeds 524.
- Mid-frame reset: run to (700,300), assert reset for 3 clocks -> outputs at reset values immediately; after release the count restarts at (0,0).
